conv_layer_out_packer: RTL and testbench

- Parametrised output stage for convolution layers.
- Accepts the post-ReLU/max-pool sample stream (data plus valid, sop, eop, sof, eof) and packs DATA_WIDTH samples PACK_NUM per word into a DDR-width word.
- Buffers packed words in a synchronous FIFO with a programmable almost-full level and frame-end tagging.
- Generalises the fixed 8-to-64-bit layer FIFO: configurable widths, depth and threshold; partial-word flush at end of frame; sof resync; sticky overflow.

---
 rtl/conv_layer_out_packer.sv | 162 ++++++++++++++++
 tb/tb_conv_layer_out_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_out_packer.sv
// rtl/conv_layer_out_packer.sv - packs sample stream into wide words and buffers them in a tagged FIFO
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   data_i, data_valid_i  : input sample stream
//   sop_i, eop_i          : line markers, accepted but not stored
//   sof_i, eof_i          : frame markers, qualified by data_valid_i
//   ddr_fifo_rd           : read request (non-showahead)
//   ddr_data_o, ddr_eof_o : read word and its end-of-frame tag
//   ddr_data_valid_o      : read data valid, one cycle after an accepted read
//   ddr_fifo_empty        : FIFO empty
//   ddr_fifo_usedw        : exact used word count
//   ddr_fifo_afull        : registered (usedw >= AFULL_LEVEL)
//   overflow_o            : sticky, a pushed word was dropped
//   frame_err_o           : one-cycle pulse when sof arrives mid-word
//   frame_cnt_o           : eof-tagged words written (only with CONV_LAYER_OUT_FRAME_CNT_EN)
//
// Optional feature macro: CONV_LAYER_OUT_FRAME_CNT_EN
module conv_layer_out_packer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PACK_NUM    = 8,
    parameter int                    FIFO_DEPTH  = 256,
    parameter int                    AFULL_LEVEL = 128,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            data_valid_i,
    input  logic                            sop_i,
    input  logic                            eop_i,
    input  logic                            sof_i,
    input  logic                            eof_i,
    input  logic                            ddr_fifo_rd,
    output logic [DATA_WIDTH*PACK_NUM-1:0]  ddr_data_o,
    output logic                            ddr_data_valid_o,
    output logic                            ddr_eof_o,
    output logic                            ddr_fifo_empty,
    output logic                            ddr_fifo_afull,
    output logic [$clog2(FIFO_DEPTH):0]     ddr_fifo_usedw,
    output logic                            overflow_o,
    output logic                            frame_err_o
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
    ,
    output logic [15:0]                     frame_cnt_o
`endif
);

    localparam int W  = DATA_WIDTH * PACK_NUM;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK_NUM - 1);

    // Line markers carry no information for the packed output.
    logic unused_line_marks;
    assign unused_line_marks = sop_i ^ eop_i;

    logic [LW-1:0] lane;
    logic [LW-1:0] eff_lane;
    logic [W-1:0]  partial;
    logic [W-1:0]  next_word;
    logic          push_valid;
    logic          push_eof;
    logic [W-1:0]  push_word;

    logic [W:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          do_rd;
    logic          do_wr;

    // A sof sample always restarts the word at lane 0, discarding any partial.
    assign eff_lane = sof_i ? '0 : lane;

    // Lanes below the current one keep earlier samples, lanes above are padded
    // (they are overwritten later unless this word is flushed now).
    always_comb begin
        next_word = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            if (LW'(i) < eff_lane)
                next_word[i*DATA_WIDTH +: DATA_WIDTH] = partial[i*DATA_WIDTH +: DATA_WIDTH];
            else if (LW'(i) == eff_lane)
                next_word[i*DATA_WIDTH +: DATA_WIDTH] = data_i;
            else
                next_word[i*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane        <= '0;
            partial     <= '0;
            push_valid  <= 1'b0;
            push_word   <= '0;
            push_eof    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            push_valid  <= 1'b0;
            frame_err_o <= 1'b0;
            if (data_valid_i) begin
                frame_err_o <= sof_i && (lane != '0);
                partial     <= next_word;
                // A full word carries eof_i; an eof flush is tagged 1, which is eof_i too.
                if (eff_lane == LAST_LANE || eof_i) begin
                    push_valid <= 1'b1;
                    push_word  <= next_word;
                    push_eof   <= eof_i;
                    lane       <= '0;
                end else begin
                    lane <= eff_lane + 1'b1;
                end
            end
        end
    end

    // The extra pointer MSB makes the difference exact, so full and empty differ.
    assign ddr_fifo_usedw = wr_ptr - rd_ptr;
    assign ddr_fifo_empty = (wr_ptr == rd_ptr);
    assign full           = (ddr_fifo_usedw == (AW+1)'(FIFO_DEPTH));
    assign do_rd          = ddr_fifo_rd && !ddr_fifo_empty;
    // A same-cycle read frees the slot the write needs.
    assign do_wr          = push_valid && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= {push_eof, push_word};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            ddr_data_o       <= '0;
            ddr_eof_o        <= 1'b0;
            ddr_data_valid_o <= 1'b0;
            ddr_fifo_afull   <= 1'b0;
            overflow_o       <= 1'b0;
        end else begin
            ddr_data_valid_o <= do_rd;
            if (do_rd) begin
                {ddr_eof_o, ddr_data_o} <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (push_valid && !do_wr)
                overflow_o <= 1'b1;
            ddr_fifo_afull <= (ddr_fifo_usedw >= (AW+1)'(AFULL_LEVEL));
        end
    end

`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            frame_cnt_o <= '0;
        else if (do_wr && push_eof)
            frame_cnt_o <= frame_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv_layer_out_packer.sv
// tb/tb_conv_layer_out_packer.sv - directed scoreboard bench for conv_layer_out_packer
module tb_conv_layer_out_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_i;
    logic        data_valid_i;
    logic        sop_i;
    logic        eop_i;
    logic        sof_i;
    logic        eof_i;
    logic        ddr_fifo_rd;
    logic [63:0] ddr_data_o;
    logic        ddr_data_valid_o;
    logic        ddr_eof_o;
    logic        ddr_fifo_empty;
    logic        ddr_fifo_afull;
    logic [2:0]  ddr_fifo_usedw;
    logic        overflow_o;
    logic        frame_err_o;
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [64:0] sb[$];
    logic [64:0] exp_e;

    always #5 clk = ~clk;

    conv_layer_out_packer #(
        .DATA_WIDTH (8),
        .PACK_NUM   (8),
        .FIFO_DEPTH (4),
        .AFULL_LEVEL(2),
        .PAD_VALUE  (8'h00)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_i          (data_i),
        .data_valid_i    (data_valid_i),
        .sop_i           (sop_i),
        .eop_i           (eop_i),
        .sof_i           (sof_i),
        .eof_i           (eof_i),
        .ddr_fifo_rd     (ddr_fifo_rd),
        .ddr_data_o      (ddr_data_o),
        .ddr_data_valid_o(ddr_data_valid_o),
        .ddr_eof_o       (ddr_eof_o),
        .ddr_fifo_empty  (ddr_fifo_empty),
        .ddr_fifo_afull  (ddr_fifo_afull),
        .ddr_fifo_usedw  (ddr_fifo_usedw),
        .overflow_o      (overflow_o),
        .frame_err_o     (frame_err_o)
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
        ,
        .frame_cnt_o     (frame_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e);
        data_i       = d;
        data_valid_i = 1'b1;
        sof_i        = s;
        eof_i        = e;
        sop_i        = s;
        eop_i        = e;
        @(negedge clk);
        data_valid_i = 1'b0;
        sof_i        = 1'b0;
        eof_i        = 1'b0;
        sop_i        = 1'b0;
        eop_i        = 1'b0;
    endtask

    // Eight samples base..base+7; the expected word is queued only if it will be stored.
    task automatic put_word(input logic [7:0] base, input logic e, input logic stored);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*8 +: 8] = base + 8'(i);
            put(base + 8'(i), 1'b0, (i == 7) ? e : 1'b0);
        end
        if (stored)
            sb.push_back({e, w});
    endtask

    task automatic rd_check(input string tag);
        ddr_fifo_rd = 1'b1;
        @(negedge clk);
        ddr_fifo_rd = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_valid0"}, 64'(ddr_data_valid_o), 64'd0);
        end else begin
            exp_e = sb.pop_front();
            chk({tag, "_valid"}, 64'(ddr_data_valid_o), 64'd1);
            chk({tag, "_data"}, ddr_data_o, exp_e[63:0]);
            chk({tag, "_eof"}, 64'(ddr_eof_o), 64'(exp_e[64]));
        end
    endtask

    task automatic do_reset();
        ddr_fifo_rd = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        data_i = '0; data_valid_i = 0; sop_i = 0; eop_i = 0;
        sof_i = 0; eof_i = 0; ddr_fifo_rd = 0;
        idle(2);
        chk("rst_empty", 64'(ddr_fifo_empty), 64'd1);
        chk("rst_usedw", 64'(ddr_fifo_usedw), 64'd0);
        chk("rst_afull", 64'(ddr_fifo_afull), 64'd0);
        chk("rst_valid", 64'(ddr_data_valid_o), 64'd0);
        chk("rst_data", ddr_data_o, 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_ferr", 64'(frame_err_o), 64'd0);
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
        chk("rst_fcnt", 64'(frame_cnt_o), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Full word, two-cycle latency to non-empty
        put_word(8'h01, 1'b0, 1'b1);
        chk("lat_empty_pre", 64'(ddr_fifo_empty), 64'd1);
        idle(1);
        chk("lat_empty_post", 64'(ddr_fifo_empty), 64'd0);
        chk("w1_usedw", 64'(ddr_fifo_usedw), 64'd1);
        rd_check("w1");

        // eof flush of a partial word
        put(8'hA1, 1'b0, 1'b0);
        put(8'hA2, 1'b0, 1'b0);
        put(8'hA3, 1'b0, 1'b1);
        sb.push_back({1'b1, 64'h0000_0000_00A3_A2A1});
        idle(2);
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
        chk("eof_fcnt", 64'(frame_cnt_o), 64'd1);
`endif
        rd_check("eof");

        // sof resync mid-word
        for (int i = 0; i < 5; i++) put(8'h11 + 8'(i), 1'b0, 1'b0);
        put(8'h55, 1'b1, 1'b0);
        chk("sof_ferr_pulse", 64'(frame_err_o), 64'd1);
        put(8'h56, 1'b0, 1'b0);
        chk("sof_ferr_clear", 64'(frame_err_o), 64'd0);
        for (int i = 0; i < 6; i++) put(8'h57 + 8'(i), 1'b0, 1'b0);
        sb.push_back({1'b0, 64'h5C5B_5A59_5857_5655});
        idle(2);
        chk("sof_usedw", 64'(ddr_fifo_usedw), 64'd1);
        rd_check("sof");

        // Fill, afull lag, overflow
        do_reset();
        put_word(8'h10, 1'b0, 1'b1);
        idle(1);
        chk("af_usedw1", 64'(ddr_fifo_usedw), 64'd1);
        put_word(8'h20, 1'b0, 1'b1);
        chk("af_usedw1b", 64'(ddr_fifo_usedw), 64'd1);
        idle(1);
        chk("af_usedw2", 64'(ddr_fifo_usedw), 64'd2);
        chk("af_lag0", 64'(ddr_fifo_afull), 64'd0);
        idle(1);
        chk("af_lag1", 64'(ddr_fifo_afull), 64'd1);
        put_word(8'h30, 1'b0, 1'b1);
        put_word(8'h40, 1'b0, 1'b1);
        put_word(8'h50, 1'b0, 1'b0);
        put_word(8'h60, 1'b0, 1'b0);
        idle(2);
        chk("ovf_usedw", 64'(ddr_fifo_usedw), 64'd4);
        chk("ovf_afull", 64'(ddr_fifo_afull), 64'd1);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 5; i++) rd_check($sformatf("ovf_rd%0d", i));

        // Full FIFO with a same-cycle read and write
        do_reset();
        put_word(8'hA0, 1'b0, 1'b1);
        put_word(8'hB0, 1'b0, 1'b1);
        put_word(8'hC0, 1'b0, 1'b1);
        put_word(8'hD0, 1'b0, 1'b1);
        idle(2);
        chk("rw_full", 64'(ddr_fifo_usedw), 64'd4);
        put_word(8'hE0, 1'b1, 1'b1);
        ddr_fifo_rd = 1'b1;
        @(negedge clk);
        ddr_fifo_rd = 1'b0;
        exp_e = sb.pop_front();
        chk("rw_valid", 64'(ddr_data_valid_o), 64'd1);
        chk("rw_data", ddr_data_o, exp_e[63:0]);
        chk("rw_usedw", 64'(ddr_fifo_usedw), 64'd4);
        chk("rw_ovf", 64'(overflow_o), 64'd0);
        idle(1);
        chk("rw_ovf_hold", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 4; i++) rd_check($sformatf("rw_rd%0d", i));

        // Reset mid-frame with buffered and partial data
        do_reset();
        put_word(8'h70, 1'b0, 1'b1);
        put_word(8'h80, 1'b0, 1'b1);
        put_word(8'h90, 1'b0, 1'b1);
        put(8'hF1, 1'b0, 1'b0);
        put(8'hF2, 1'b0, 1'b0);
        chk("mid_afull_pre", 64'(ddr_fifo_afull), 64'd1);
        do_reset();
        chk("mid_empty", 64'(ddr_fifo_empty), 64'd1);
        chk("mid_usedw", 64'(ddr_fifo_usedw), 64'd0);
        chk("mid_afull", 64'(ddr_fifo_afull), 64'd0);
`ifdef CONV_LAYER_OUT_FRAME_CNT_EN
        chk("mid_fcnt", 64'(frame_cnt_o), 64'd0);
`endif
        put_word(8'hC1, 1'b0, 1'b1);
        idle(2);
        chk("clean_usedw", 64'(ddr_fifo_usedw), 64'd1);
        rd_check("clean");
        rd_check("clean_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
